// File: rtl/cnt_down_pkg.sv
// -----------------------------------------------------------------------------
// cnt_down_pkg
//   Shared definitions for the multi-channel down-counter/timer:
//     - ch_state_e  : per-channel state (IDLE / RUN)
//     - DEF_BW/NCH/PW : default counter width, channel count, prescaler width
//     - slice_lo()  : low bit index of element idx in a packed vector of
//                     width-sized elements
// -----------------------------------------------------------------------------
package cnt_down_pkg;

  localparam int DEF_BW  = 8;
  localparam int DEF_NCH = 4;
  localparam int DEF_PW  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  // Low bit of element idx inside a packed bus of width-bit elements.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage : cnt_down_pkg

// File: rtl/cnt_down_ch.sv
// -----------------------------------------------------------------------------
// cnt_down_ch
//   One channel of the multi-channel down-counter. Holds the count, the
//   reload value, the IDLE/RUN state, the one-cycle expiry pulse and the
//   sticky expiry flag. The shared tick comes from the parent.
//
// Ports
//   CLK        clock, all state on rising edge
//   RSTX       asynchronous active-low reset
//   tick_i     shared timebase tick (already gated by the global enable)
//   load_i     load strobe: count and reload take val_i, channel enters RUN
//   val_i      load value
//   dec_i      decrement enable for this channel
//   oneshot_i  1 = go IDLE on expiry, 0 = reload and keep running
//   clr_i      clears the sticky flag (an expiry in the same cycle wins)
//   cnt_o      current count
//   cnt0_o     combinational cnt_o == 0
//   run_o      channel is in RUN
//   exp_o      registered one-cycle expiry pulse
//   sticky_o   latched expiry flag
// -----------------------------------------------------------------------------
module cnt_down_ch
  import cnt_down_pkg::*;
#(
  parameter int BW = DEF_BW
) (
  input  logic          CLK,
  input  logic          RSTX,
  input  logic          tick_i,
  input  logic          load_i,
  input  logic [BW-1:0] val_i,
  input  logic          dec_i,
  input  logic          oneshot_i,
  input  logic          clr_i,
  output logic [BW-1:0] cnt_o,
  output logic          cnt0_o,
  output logic          run_o,
  output logic          exp_o,
  output logic          sticky_o
);

  ch_state_e     state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] rld_q, rld_d;
  logic          exp_q, exp_d;
  logic          sticky_q, sticky_d;

  logic          advance;
  logic          cnt_zero;

  assign cnt_zero = (cnt_q == '0);
  // Ticks and DEC only matter while running; in IDLE the count is frozen.
  assign advance  = (state_q == ST_RUN) && tick_i && dec_i;

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rld_q    <= '0;
      exp_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rld_q    <= rld_d;
      exp_q    <= exp_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rld_d    = rld_q;
    exp_d    = 1'b0;
    // Clear first so that an expiry below overrides a coincident CLR.
    sticky_d = sticky_q & ~clr_i;

    if (load_i) begin
      // Load beats everything, including an expiry on the same tick.
      cnt_d   = val_i;
      rld_d   = val_i;
      state_d = ST_RUN;
    end else if (advance) begin
      if (!cnt_zero) begin
        cnt_d = cnt_q - BW'(1);
      end else begin
        // Expiry: count has sat at zero for one full tick.
        exp_d    = 1'b1;
        sticky_d = 1'b1;
        if (oneshot_i) begin
          // Count stays at zero; no wrap to all-ones.
          state_d = ST_IDLE;
        end else begin
          cnt_d = rld_q;
        end
      end
    end
  end

  assign cnt_o    = cnt_q;
  assign cnt0_o   = cnt_zero;
  assign run_o    = (state_q == ST_RUN);
  assign exp_o    = exp_q;
  assign sticky_o = sticky_q;

endmodule : cnt_down_ch

// File: rtl/cnt_down_multi.sv
// -----------------------------------------------------------------------------
// cnt_down_multi
//   Multi-channel programmable down-counter/timer. NCH independent channels
//   share one prescaler and the global enable. This level owns only the
//   prescaler and the packing of per-channel signals onto the flat ports.
//
// Build option
//   CNT_DOWN_MULTI_PRESCALE_EN
//     defined   : prescaler present, tick period = PRE+1 enabled cycles
//     undefined : tick = EN, PRE is accepted but ignored, no prescaler flops
//
// Ports
//   CLK      clock, all state on rising edge
//   RSTX     asynchronous active-low reset
//   EN       global enable; gates the prescaler and all ticks
//   PRE      prescaler divide value
//   LOAD     per-channel load strobe
//   VAL      per-channel load value, channel i at [i*BW +: BW]
//   DEC      per-channel decrement enable
//   ONESHOT  per-channel mode, 1 = one-shot, 0 = periodic
//   CLR      per-channel sticky clear
//   CNT      per-channel count, packed like VAL
//   CNT0     per-channel combinational count == 0
//   RUN      per-channel RUN state
//   EXP      per-channel registered one-cycle expiry pulse
//   STICKY   per-channel latched expiry flag
// -----------------------------------------------------------------------------
module cnt_down_multi
  import cnt_down_pkg::*;
#(
  parameter int BW  = DEF_BW,
  parameter int NCH = DEF_NCH,
  parameter int PW  = DEF_PW
) (
  input  logic              CLK,
  input  logic              RSTX,
  input  logic              EN,
  input  logic [PW-1:0]     PRE,
  input  logic [NCH-1:0]    LOAD,
  input  logic [NCH*BW-1:0] VAL,
  input  logic [NCH-1:0]    DEC,
  input  logic [NCH-1:0]    ONESHOT,
  input  logic [NCH-1:0]    CLR,
  output logic [NCH*BW-1:0] CNT,
  output logic [NCH-1:0]    CNT0,
  output logic [NCH-1:0]    RUN,
  output logic [NCH-1:0]    EXP,
  output logic [NCH-1:0]    STICKY
);

  logic tick;

`ifdef CNT_DOWN_MULTI_PRESCALE_EN
  logic [PW-1:0] pre_q, pre_d;

  // Counts PRE..0 while enabled. PRE is only sampled on the reload, so a
  // new divide value starts with the next period. Reset to 0 gives a tick
  // in the very first enabled cycle.
  always_comb begin
    pre_d = pre_q;
    if (EN) begin
      if (pre_q == '0) begin
        pre_d = PRE;
      end else begin
        pre_d = pre_q - PW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick = EN && (pre_q == '0);
`else
  // PRE stays on the port for interface compatibility only.
  logic pre_unused;
  assign pre_unused = ^PRE;
  assign tick       = EN;
`endif

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    cnt_down_ch #(
      .BW (BW)
    ) u_ch (
      .CLK       (CLK),
      .RSTX      (RSTX),
      .tick_i    (tick),
      .load_i    (LOAD[gi]),
      .val_i     (VAL[slice_lo(gi, BW) +: BW]),
      .dec_i     (DEC[gi]),
      .oneshot_i (ONESHOT[gi]),
      .clr_i     (CLR[gi]),
      .cnt_o     (CNT[slice_lo(gi, BW) +: BW]),
      .cnt0_o    (CNT0[gi]),
      .run_o     (RUN[gi]),
      .exp_o     (EXP[gi]),
      .sticky_o  (STICKY[gi])
    );
  end

endmodule : cnt_down_multi

// File: tb/tb_cnt_down_multi.sv
// -----------------------------------------------------------------------------
// tb_cnt_down_multi
//   Self-checking bench for cnt_down_multi. A behavioural model built from
//   the timer rules (integer counts, booleans) runs alongside the DUT; each
//   scenario task compares the DUT against it and adds directed checks.
// -----------------------------------------------------------------------------
module tb_cnt_down_multi;

  localparam int BW  = 8;
  localparam int NCH = 4;
  localparam int PW  = 4;
  localparam int VW  = NCH*BW + 4*NCH;

  logic              CLK = 1'b0;
  logic              RSTX = 1'b0;
  logic              EN = 1'b0;
  logic [PW-1:0]     PRE = '0;
  logic [NCH-1:0]    LOAD = '0;
  logic [NCH*BW-1:0] VAL = '0;
  logic [NCH-1:0]    DEC = '0;
  logic [NCH-1:0]    ONESHOT = '0;
  logic [NCH-1:0]    CLR = '0;
  logic [NCH*BW-1:0] CNT;
  logic [NCH-1:0]    CNT0;
  logic [NCH-1:0]    RUN;
  logic [NCH-1:0]    EXP;
  logic [NCH-1:0]    STICKY;

  cnt_down_multi #(.BW(BW), .NCH(NCH), .PW(PW)) dut (
    .CLK     (CLK),
    .RSTX    (RSTX),
    .EN      (EN),
    .PRE     (PRE),
    .LOAD    (LOAD),
    .VAL     (VAL),
    .DEC     (DEC),
    .ONESHOT (ONESHOT),
    .CLR     (CLR),
    .CNT     (CNT),
    .CNT0    (CNT0),
    .RUN     (RUN),
    .EXP     (EXP),
    .STICKY  (STICKY)
  );

  always #5 CLK = ~CLK;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {CNT, CNT0, RUN, EXP, STICKY};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  int m_pre;
  int m_cnt [NCH];
  int m_rld [NCH];
  bit m_run [NCH];
  bit m_exp [NCH];
  bit m_sticky [NCH];

`ifdef CNT_DOWN_MULTI_PRESCALE_EN
  localparam int BASE_PERIOD = 8;  // (PRE+1)*(VAL+1) = 4*2
`else
  localparam int BASE_PERIOD = 2;  // one tick per cycle, VAL+1 = 2
`endif

  task automatic model_reset();
    m_pre = 0;
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_rld[i] = 0; m_run[i] = 0; m_exp[i] = 0; m_sticky[i] = 0;
    end
  endtask

  function automatic bit model_tick();
`ifdef CNT_DOWN_MULTI_PRESCALE_EN
    return EN && (m_pre == 0);
`else
    return EN;
`endif
  endfunction

  // One rising edge worth of behaviour, using the inputs present at the edge.
  task automatic model_update();
    bit t;
    if (!RSTX) begin
      model_reset();
      return;
    end
    t = model_tick();
    if (EN) m_pre = (m_pre == 0) ? int'(PRE) : m_pre - 1;
    for (int i = 0; i < NCH; i++) begin
      m_exp[i] = 0;
      if (CLR[i]) m_sticky[i] = 0;
      if (LOAD[i]) begin
        m_cnt[i] = int'(VAL[i*BW +: BW]);
        m_rld[i] = m_cnt[i];
        m_run[i] = 1;
      end else if (m_run[i] && t && DEC[i]) begin
        if (m_cnt[i] > 0) begin
          m_cnt[i] = m_cnt[i] - 1;
        end else begin
          m_exp[i]    = 1;
          m_sticky[i] = 1;
          if (ONESHOT[i]) m_run[i] = 0;
          else            m_cnt[i] = m_rld[i];
        end
      end
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [NCH*BW-1:0] c;
    logic [NCH-1:0] z, r, e, s;
    for (int i = 0; i < NCH; i++) begin
      c[i*BW +: BW] = BW'(m_cnt[i]);
      z[i] = (m_cnt[i] == 0);
      r[i] = m_run[i];
      e[i] = m_exp[i];
      s[i] = m_sticky[i];
    end
    return {c, z, r, e, s};
  endfunction

  // Advance one clock; model follows; returns 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    LOAD = '0; CLR = '0; DEC = '0; EN = 1'b0; ONESHOT = '0; VAL = '0; PRE = '0;
    RSTX = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTX = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (dut_vec !== model_vec()) begin
      n_bad++;
      $display("FAIL reset_vec got=%h want=%h", dut_vec, model_vec());
    end
    n_cmp++;
    if (CNT0 !== 4'hF || RUN !== 4'h0 || EXP !== 4'h0 || STICKY !== 4'h0 || CNT !== '0) begin
      n_bad++;
      $display("FAIL reset_values got cnt=%h cnt0=%b run=%b exp=%b sticky=%b want cnt=0 cnt0=1111 run/exp/sticky=0",
               CNT, CNT0, RUN, EXP, STICKY);
    end
    $display("test_reset: checked reset state");
  endtask

  task automatic test_periodic();
    int want;
    do_reset();
    EN = 1; PRE = '0; DEC = 4'b0001; ONESHOT = '0;
    VAL[0 +: BW] = 8'd3; LOAD = 4'b0001;
    step();
    LOAD = '0;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL periodic_model k=%0d got=%h want=%h", k, dut_vec, model_vec());
      end
      want = 3 - (k % 4);
      n_cmp++;
      if (CNT[0 +: BW] !== BW'(want) || EXP[0] !== (k % 4 == 0) || STICKY[0] !== (k >= 4)) begin
        n_bad++;
        $display("FAIL periodic_seq k=%0d got cnt=%0d exp=%b sticky=%b want cnt=%0d exp=%b sticky=%b",
                 k, CNT[0 +: BW], EXP[0], STICKY[0], want, (k % 4 == 0), (k >= 4));
      end
    end
    $display("test_periodic: ch0 VAL=3 periodic, 12 cycles");
  endtask

  task automatic test_oneshot();
    int nexp = 0;
    do_reset();
    EN = 1; PRE = '0; DEC = 4'b0010; ONESHOT = 4'b0010;
    VAL[BW +: BW] = 8'd2; LOAD = 4'b0010;
    step();
    LOAD = '0;
    for (int k = 1; k <= 23; k++) begin
      step();
      if (EXP[1] === 1'b1) nexp++;
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL oneshot_model k=%0d got=%h want=%h", k, dut_vec, model_vec());
      end
      n_cmp++;
      if (EXP[1] !== (k == 3) || RUN[1] !== (k < 3)) begin
        n_bad++;
        $display("FAIL oneshot_seq k=%0d got exp=%b run=%b want exp=%b run=%b",
                 k, EXP[1], RUN[1], (k == 3), (k < 3));
      end
    end
    n_cmp++;
    if (nexp != 1 || CNT[BW +: BW] !== 8'd0) begin
      n_bad++;
      $display("FAIL oneshot_final got exps=%0d cnt=%0d want exps=1 cnt=0", nexp, CNT[BW +: BW]);
    end
    $display("test_oneshot: ch1 VAL=2 one-shot, %0d expiry pulses", nexp);
  endtask

  task automatic test_prescale();
    int t[$];
    int n_low = 0;
    do_reset();
    EN = 1; PRE = 4'd3; DEC = 4'b0001; ONESHOT = '0;
    VAL[0 +: BW] = 8'd1; LOAD = 4'b0001;
    step();
    LOAD = '0;
    for (int k = 1; k <= 200 && t.size() < 4; k++) begin
      step();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL prescale_model k=%0d got=%h want=%h", k, dut_vec, model_vec());
      end
      if (EXP[0] === 1'b1) begin
        t.push_back(k);
        if (t.size() == 3) begin
          EN = 0;
          n_low = 5;
        end
      end else if (n_low > 0) begin
        n_low--;
        if (n_low == 0) EN = 1;
      end
    end
    EN = 1;
    n_cmp++;
    if (t.size() < 4) begin
      n_bad++;
      $display("FAIL prescale_timeout got %0d expiries want 4", t.size());
    end else begin
      if (t[2] - t[1] != BASE_PERIOD) begin
        n_bad++;
        $display("FAIL prescale_period got=%0d want=%0d", t[2] - t[1], BASE_PERIOD);
      end
      n_cmp++;
      if (t[3] - t[2] != BASE_PERIOD + 5) begin
        n_bad++;
        $display("FAIL prescale_en_gap got=%0d want=%0d", t[3] - t[2], BASE_PERIOD + 5);
      end
      $display("test_prescale: intervals %0d and %0d cycles", t[2] - t[1], t[3] - t[2]);
    end
  endtask

  task automatic test_load_midcount();
    int guard;
    do_reset();
    EN = 1; PRE = '0; DEC = 4'b0100; ONESHOT = '0;
    VAL[2*BW +: BW] = 8'd7; LOAD = 4'b0100;
    step();
    LOAD = '0;
    guard = 0;
    while (m_cnt[2] != 4 && guard < 20) begin
      step(); guard++;
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL midload_model got=%h want=%h", dut_vec, model_vec());
      end
    end
    VAL[2*BW +: BW] = 8'd10; LOAD = 4'b0100;
    step();
    LOAD = '0;
    n_cmp++;
    if (CNT[2*BW +: BW] !== 8'd10 || EXP[2] !== 1'b0 || guard >= 20) begin
      n_bad++;
      $display("FAIL midload_reload got cnt=%0d exp=%b guard=%0d want cnt=10 exp=0", CNT[2*BW +: BW], EXP[2], guard);
    end
    guard = 0;
    while (m_cnt[2] != 0 && guard < 20) begin
      step(); guard++;
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL midload_model2 got=%h want=%h", dut_vec, model_vec());
      end
    end
    VAL[2*BW +: BW] = 8'd5; LOAD = 4'b0100;
    step();
    LOAD = '0;
    n_cmp++;
    if (CNT[2*BW +: BW] !== 8'd5 || EXP[2] !== 1'b0 || STICKY[2] !== 1'b0 || guard >= 20) begin
      n_bad++;
      $display("FAIL load_on_expiry got cnt=%0d exp=%b sticky=%b want cnt=5 exp=0 sticky=0",
               CNT[2*BW +: BW], EXP[2], STICKY[2]);
    end
    $display("test_load_midcount: ch2 reloaded at 4 and at 0");
  endtask

  task automatic test_sticky();
    int guard = 0;
    do_reset();
    EN = 1; PRE = '0; DEC = 4'b1000; ONESHOT = '0;
    VAL[3*BW +: BW] = 8'd1; LOAD = 4'b1000;
    step();
    LOAD = '0;
    while (!(m_cnt[3] == 0 && m_run[3]) && guard < 20) begin
      step(); guard++;
    end
    CLR = 4'b1000;
    step();
    n_cmp++;
    if (STICKY[3] !== 1'b1 || EXP[3] !== 1'b1 || guard >= 20) begin
      n_bad++;
      $display("FAIL sticky_set_wins got sticky=%b exp=%b want sticky=1 exp=1", STICKY[3], EXP[3]);
    end
    step();
    CLR = '0;
    n_cmp++;
    if (STICKY[3] !== 1'b0 || dut_vec !== model_vec()) begin
      n_bad++;
      $display("FAIL sticky_clear got sticky=%b vec=%h want sticky=0 vec=%h", STICKY[3], dut_vec, model_vec());
    end
    $display("test_sticky: ch3 clear vs expiry");
  endtask

  task automatic test_all_zero_reset();
    do_reset();
    EN = 1; PRE = '0; DEC = 4'hF; ONESHOT = '0; VAL = '0; LOAD = 4'hF;
    step();
    LOAD = '0;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_cmp++;
      if (EXP !== 4'hF || CNT !== '0 || dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL all_zero k=%0d got exp=%b cnt=%h want exp=1111 cnt=0", k, EXP, CNT);
      end
    end
    #2;
    RSTX = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (CNT !== '0 || CNT0 !== 4'hF || RUN !== 4'h0 || EXP !== 4'h0 || STICKY !== 4'h0) begin
      n_bad++;
      $display("FAIL async_reset got cnt=%h cnt0=%b run=%b exp=%b sticky=%b want 0/1111/0/0/0",
               CNT, CNT0, RUN, EXP, STICKY);
    end
    @(negedge CLK);
    @(negedge CLK);
    RSTX = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++;
      if (EXP !== 4'h0 || RUN !== 4'h0 || dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL post_reset k=%0d got exp=%b run=%b want exp=0 run=0", k, EXP, RUN);
      end
    end
    $display("test_all_zero_reset: 4 channels VAL=0, async reset mid-run");
  endtask

  task automatic test_random();
    int nerr0 = n_bad;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      EN = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) PRE = PW'($urandom_range(0, 3));
      for (int i = 0; i < NCH; i++) begin
        LOAD[i] = ($urandom_range(0, 29) == 0);
        VAL[i*BW +: BW] = BW'($urandom_range(0, 6));
        DEC[i] = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 49) == 0) ONESHOT[i] = ~ONESHOT[i];
        CLR[i] = ($urandom_range(0, 14) == 0);
      end
      step();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL random k=%0d got=%h want=%h", k, dut_vec, model_vec());
      end
    end
    LOAD = '0; CLR = '0;
    $display("test_random: 1500 cycles, %0d new mismatches", n_bad - nerr0);
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_prescale();
    test_load_midcount();
    test_sticky();
    test_all_zero_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout at cycle %0d want completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule : tb_cnt_down_multi

// File: doc/cnt_down_multi.md
# cnt_down_multi

Multi-channel programmable down-counter/timer for the BER test datapath. It is the parametrised successor of the single-channel down counter: NCH independent channels share one prescaler and the global enable. Each channel has its own reload register, one-shot or periodic mode, an expiry pulse and a sticky expiry flag. It sits between the BER control registers and the gate-time/interval logic of the error counters.

## Interface
- BW, 8, counter and reload width per channel
- NCH, 4, number of channels (1..16)
- PW, 4, prescaler width
- CLK  in  1  clock, all state on rising edge
- RSTX  in  1  reset, asynchronous, active-low
- EN  in  1  global enable; gates the prescaler and all ticks
- PRE  in  PW  prescaler divide value; tick period = PRE+1 cycles
- LOAD  in  NCH  per-channel load strobe
- VAL  in  NCH*BW  per-channel load value, channel i at [i*BW +: BW]
- DEC  in  NCH  per-channel decrement enable
- ONESHOT  in  NCH  1 = one-shot mode, 0 = periodic mode
- CLR  in  NCH  clears STICKY
- CNT  out  NCH*BW  current count, packed like VAL
- CNT0  out  NCH  combinational, CNT[i]==0
- RUN  out  NCH  channel is in RUN state
- EXP  out  NCH  registered one-cycle expiry pulse
- STICKY  out  NCH  latched expiry flag

## Operation
- Each channel has two states, IDLE and RUN. An expired one-shot channel returns to IDLE.
- tick = EN && (prescaler == 0).
- The prescaler counts down from PRE to 0. On reaching 0 it reloads PRE, but only when EN=1. It holds while EN=0.
- A new PRE value takes effect at the next prescaler reload.
- LOAD[i] has the highest priority:
  - CNT<=VAL, RLD<=VAL, state<=RUN, EXP<=0.
  - This applies in any state, including mid-count.
- A channel advances in RUN only when tick && DEC[i]. Otherwise it holds.
- On an advance with CNT!=0: CNT<=CNT-1.
- On an advance with CNT==0 (expiry): EXP<=1 for one cycle and STICKY<=1.
  - Periodic mode: CNT<=RLD and the channel stays in RUN.
  - One-shot mode: CNT stays 0 and state<=IDLE.
- Expiry interval in ticks is RLD+1. RLD=0 in periodic mode expires on every tick.
- No wrap-around: CNT never goes below 0, and 0 followed by {BW{1}} never occurs.
- ONESHOT is sampled at the expiry edge, so changing it mid-count affects only the next expiry.
- STICKY is set by expiry and cleared by CLR[i]. If set and CLR coincide, set wins.
- In IDLE, DEC and tick are ignored and CNT holds.
- Channels are fully independent; simultaneous expiries on several channels are all reported in the same cycle.

## Timing
- Reset values:
  - CNT=0, RLD=0, prescaler=0.
  - RUN=0, EXP=0, STICKY=0.
  - CNT0=1 (follows CNT).
- LOAD is visible on CNT and RUN one cycle later.
- EXP, the reload/idle transition and STICKY all appear on the same edge that samples the expiring tick.
- CNT0 has zero latency from CNT.
- Asserting RSTX mid-count clears everything immediately. There is no pending expiry after release.
- First tick after reset with EN=1 occurs in the first cycle, because the prescaler resets to 0.

## Configuration
- CNT_DOWN_MULTI_PRESCALE_EN
  - Defined: prescaler present and PRE honoured.
  - Undefined: tick = EN, the PRE port stays in the interface but is ignored, and no prescaler flops exist.

## Structure
- Package cnt_down_pkg holds:
  - the channel state enum (IDLE, RUN);
  - default BW/NCH/PW constants;
  - a function for packed-slice indexing.
- Sub-module cnt_down_ch implements one channel (state, CNT, RLD, EXP, STICKY). It takes tick as an input and is instantiated NCH times in a generate loop.
- The top level owns only the prescaler and the port packing.

## Test plan
- Reset with EN=1, PRE=0, LOAD[0]=1 and VAL=3, periodic, DEC=1 → CNT sequence 3,2,1,0,3,… with EXP[0] every 4th cycle and STICKY[0]=1 after the first expiry.
- One-shot: ch1 loaded with VAL=2 and ONESHOT=1 → CNT 2,1,0; EXP pulse; RUN drops; CNT holds 0 for 20 cycles with no further EXP.
- Prescaler (macro defined): PRE=3 and VAL=1 → EXP every 8 cycles. Toggling EN low for 5 cycles extends the next interval to 13 cycles. With the macro undefined, the same stimulus gives EXP every 2 cycles.
- LOAD mid-count: reload ch2 with VAL=10 when CNT=4 → next CNT=10 with no EXP. LOAD on the same cycle as an expiry tick → CNT=VAL and no EXP.
- STICKY: CLR[3] coincident with expiry → STICKY stays 1. CLR alone the next cycle → STICKY=0.
- All 4 channels loaded with VAL=0, periodic → EXP=4'b1111 every tick. Asserting RSTX mid-run → all outputs at reset values asynchronously.
